btb_update_controller: RTL and testbench
========================================

Name: btb_update_controller

Overview:
Owns the branch target buffer table and sequences every change to it. Fetch performs a combinational lookup. Execute posts resolved branches over a valid/ready port. A small FSM performs each read-modify-write: tag check, then a 2-bit saturating counter step or a new-entry allocation. Flushes walk the table one entry per cycle, so the table can be remapped to single-port RAM later.

Parameters:
ENTRIES, 16, number of direct-mapped entries; power of two, ≥2
ADDR_W, 32, PC/target width
IDX_W, $clog2(ENTRIES), derived; index = pc[IDX_W+1:2], tag = pc[ADDR_W-1:IDX_W+2]

Ports:
btb_ctrl_clk  in  1  clock, rising edge
btb_ctrl_rst_n  in  1  reset, asynchronous, active-low
btb_ctrl_flush  in  1  level; request invalidation of all entries
btb_ctrl_lookup_pc  in  ADDR_W  fetch PC
btb_ctrl_hit  out  1  lookup entry valid and tag match
btb_ctrl_pred_taken  out  1  hit && counter[1]
btb_ctrl_pred_target  out  ADDR_W  stored target on hit, else 0
btb_ctrl_upd_valid  in  1  resolved-branch update offered
btb_ctrl_upd_ready  out  1  controller accepts update this cycle
btb_ctrl_upd_pc  in  ADDR_W  PC of resolved branch
btb_ctrl_upd_taken  in  1  actual outcome
btb_ctrl_upd_target  in  ADDR_W  actual target
btb_ctrl_busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, btb_ctrl_clk. Reset btb_ctrl_rst_n is asynchronous, active-low.
- Reset state: state=IDLE, all valid=0, counters=00, tags/targets=0, flush index=0.
- Outputs after reset: hit=0, pred_taken=0, pred_target=0, busy=0, upd_ready=1, provided flush=0.
- Lookup: purely combinational from table registers.
  - Forced hit=0 / pred_taken=0 / pred_target=0 while state=FLUSH.
  - No write bypass: a lookup in the same cycle as a write sees the old entry.
- Counter step, in sub-module:
  - Taken: 00→01, 01→10, 10→11, 11→11.
  - Not taken: 00→00, 01→00, 10→01, 11→10.
- FSM states: IDLE, UPDATE, FLUSH.
- IDLE:
  - upd_ready = !flush.
  - flush=1 → FLUSH, flush index=0; any upd_valid that cycle is not accepted.
  - upd_valid && upd_ready → latch pc/taken/target → UPDATE.
- UPDATE (1 cycle; upd_ready=0). Read entry[idx] and write it at the cycle end:
  - Hit, taken: counter=step(counter,1), target=upd_target.
  - Hit, not taken: counter=step(counter,0), target unchanged.
  - Miss, taken: allocate: valid=1, tag, target, counter=10 (weak taken). Overwrites any valid entry at that index.
  - Miss, not taken: no write.
  - Exit to IDLE. Throughput: one update per 2 cycles.
  - flush=1 during UPDATE: the latched update is discarded (no write) → FLUSH, index=0.
- FLUSH (upd_ready=0):
  - Each cycle: clear valid[index] and set counter to 00, then index++.
  - At index=ENTRIES-1 → IDLE after clearing; total exactly ENTRIES cycles.
  - flush still high on that last cycle → stay in FLUSH, restart at index=0.
  - flush re-asserted mid-walk → restart at index=0.
- Reset asserted mid-operation: immediate return to the reset state. A latched update is lost.
- Width rules:
  - Index/tag slices are fixed as in Parameters; pc[1:0] is ignored.
  - Flush index is IDX_W bits and wraps only via the FSM exit.

Decomposition:
- Package btb_pkg:
  - Counter encodings CTR_STRONG_NT=2'b00, CTR_WEAK_NT=2'b01, CTR_WEAK_T=2'b10, CTR_STRONG_T=2'b11.
  - FSM enum btb_ctrl_state_t {IDLE, UPDATE, FLUSH}.
  - Entry struct {valid, tag, target, ctr}.
- One sub-module, btb_sat_counter: combinational (ctr, taken) → next ctr, exactly the step table above.

Test Plan:
- Reset → hit=0, ready=1, busy=0. Lookup pc=0x100 → hit=0, pred_target=0.
- Update pc=0x100, taken, target=0x200 → next cycle busy=1, ready=0. Cycle after, lookup 0x100 → hit=1, pred_taken=1, target=0x200.
- Same pc: 2× not-taken from ctr=10 → ctr 01 then 00, pred_taken=0, hit=1. Then 3× taken → 01, 10, 11. Then 1 more taken → stays 11.
- Aliasing: pc=0x100 allocated, then taken update pc=0x140 (same index, ENTRIES=16) → lookup 0x100 hit=0, lookup 0x140 hit=1. Not-taken miss at pc=0x180 → no allocation, 0x140 unchanged.
- Flush asserted with upd_valid=1 in IDLE:
  - Update not accepted; busy for exactly 16 cycles; lookups forced hit=0; all entries invalid afterward.
  - Re-assert flush at cycle 5 → total 5+16 cycles.
- Flush during UPDATE → pending update not written. Async reset mid-FLUSH → outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/btb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btb_pkg
//  Description : Shared types and encodings for the BTB update controller:
//                2-bit counter encodings, controller FSM states and the
//                table entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package btb_pkg;

    // 2-bit saturating branch-direction counter encodings
    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    // Width of the tag and target fields held in a table entry. Tags are
    // stored zero-extended into this field, so the controller's ADDR_W must
    // not exceed it.
    localparam int BTB_FIELD_W = 32;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        FLUSH  = 2'd2
    } btb_ctrl_state_t;

    // One direct-mapped BTB entry
    typedef struct packed {
        logic                   valid;
        logic [BTB_FIELD_W-1:0] tag;
        logic [BTB_FIELD_W-1:0] target;
        logic [1:0]             ctr;
    } btb_entry_t;

endpackage : btb_pkg
`default_nettype wire

// File: rtl/btb_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : btb_sat_counter
//  Description : Combinational 2-bit saturating counter step. Taken moves
//                toward strong-taken, not-taken toward strong-not-taken,
//                both saturating at the ends.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_sat_counter
    import btb_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    // Explicit step table so the saturation points are obvious at a glance
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            case (ctr_i)
                CTR_STRONG_NT: ctr_o = CTR_WEAK_NT;
                CTR_WEAK_NT:   ctr_o = CTR_WEAK_T;
                CTR_WEAK_T:    ctr_o = CTR_STRONG_T;
                default:       ctr_o = CTR_STRONG_T;
            endcase
        end else begin
            case (ctr_i)
                CTR_STRONG_T:  ctr_o = CTR_WEAK_T;
                CTR_WEAK_T:    ctr_o = CTR_WEAK_NT;
                CTR_WEAK_NT:   ctr_o = CTR_STRONG_NT;
                default:       ctr_o = CTR_STRONG_NT;
            endcase
        end
    end

endmodule : btb_sat_counter
`default_nettype wire

// File: rtl/btb_update_controller.sv
`default_nettype none
// ============================================================================
//  Module      : btb_update_controller
//  Description : Owns a direct-mapped branch target buffer. Fetch reads it
//                combinationally; resolved branches arrive over a
//                valid/ready port and are applied by a one-cycle
//                read-modify-write. Flush walks the table one entry per
//                cycle so the storage can later become a single-port RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_update_controller
    import btb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32
)(
    input  logic              btb_ctrl_clk,
    input  logic              btb_ctrl_rst_n,
    input  logic              btb_ctrl_flush,
    input  logic [ADDR_W-1:0] btb_ctrl_lookup_pc,
    output logic              btb_ctrl_hit,
    output logic              btb_ctrl_pred_taken,
    output logic [ADDR_W-1:0] btb_ctrl_pred_target,
    input  logic              btb_ctrl_upd_valid,
    output logic              btb_ctrl_upd_ready,
    input  logic [ADDR_W-1:0] btb_ctrl_upd_pc,
    input  logic              btb_ctrl_upd_taken,
    input  logic [ADDR_W-1:0] btb_ctrl_upd_target,
    output logic              btb_ctrl_busy
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    btb_ctrl_state_t   state_q, state_d;
    logic [IDX_W-1:0]  flush_idx_q, flush_idx_d;
    btb_entry_t        table_q [ENTRIES];

    // Latched update (word-aligned PC only; pc[1:0] carries no information)
    logic [ADDR_W-1:2] upd_pc_q;
    logic              upd_taken_q;
    logic [ADDR_W-1:0] upd_target_q;
    logic              latch_en;

    // Single table write port shared by the update and flush paths
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    btb_entry_t        wr_entry;

    // The two low PC bits never select or tag an entry
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{btb_ctrl_lookup_pc[1:0], btb_ctrl_upd_pc[1:0]};

    // ------------------------------------------------------------------------
    // Fetch lookup: reads the registered table, so a same-cycle write is
    // not visible until the following cycle.
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    btb_entry_t       lk_entry;
    logic             lk_match;

    assign lk_idx   = btb_ctrl_lookup_pc[IDX_W+1:2];
    assign lk_tag   = btb_ctrl_lookup_pc[ADDR_W-1:IDX_W+2];
    assign lk_entry = table_q[lk_idx];
    assign lk_match = lk_entry.valid && (lk_entry.tag == BTB_FIELD_W'(lk_tag));

    // Lookup outputs, suppressed while the table is mid-invalidation
    always_comb begin
        btb_ctrl_hit         = 1'b0;
        btb_ctrl_pred_taken  = 1'b0;
        btb_ctrl_pred_target = '0;
        if (state_q != FLUSH && lk_match) begin
            btb_ctrl_hit         = 1'b1;
            btb_ctrl_pred_taken  = lk_entry.ctr[1];
            btb_ctrl_pred_target = ADDR_W'(lk_entry.target);
        end
    end

    assign btb_ctrl_busy = (state_q != IDLE);

    // ------------------------------------------------------------------------
    // Update read side: entry addressed by the latched PC
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       upd_entry;
    logic             upd_hit;
    logic [1:0]       ctr_next;

    assign upd_idx   = upd_pc_q[IDX_W+1:2];
    assign upd_tag   = upd_pc_q[ADDR_W-1:IDX_W+2];
    assign upd_entry = table_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == BTB_FIELD_W'(upd_tag));

    btb_sat_counter u_sat_counter (
        .ctr_i   (upd_entry.ctr),
        .taken_i (upd_taken_q),
        .ctr_o   (ctr_next)
    );

    // ------------------------------------------------------------------------
    // Next-state, handshake and table-write decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_d            = state_q;
        flush_idx_d        = flush_idx_q;
        btb_ctrl_upd_ready = 1'b0;
        latch_en           = 1'b0;
        wr_en              = 1'b0;
        wr_idx             = upd_idx;
        wr_entry           = upd_entry;

        case (state_q)
            IDLE: begin
                // Flush has priority; an update offered alongside it is refused
                btb_ctrl_upd_ready = !btb_ctrl_flush;
                if (btb_ctrl_flush) begin
                    state_d     = FLUSH;
                    flush_idx_d = '0;
                end else if (btb_ctrl_upd_valid) begin
                    latch_en = 1'b1;
                    state_d  = UPDATE;
                end
            end

            UPDATE: begin
                if (btb_ctrl_flush) begin
                    // Pending update is dropped; the table is about to be wiped
                    state_d     = FLUSH;
                    flush_idx_d = '0;
                end else begin
                    state_d = IDLE;
                    if (upd_hit) begin
                        wr_en        = 1'b1;
                        wr_entry.ctr = ctr_next;
                        if (upd_taken_q) begin
                            wr_entry.target = BTB_FIELD_W'(upd_target_q);
                        end
                    end else if (upd_taken_q) begin
                        // Allocate, evicting whatever shares this index
                        wr_en           = 1'b1;
                        wr_entry.valid  = 1'b1;
                        wr_entry.tag    = BTB_FIELD_W'(upd_tag);
                        wr_entry.target = BTB_FIELD_W'(upd_target_q);
                        wr_entry.ctr    = CTR_WEAK_T;
                    end
                end
            end

            FLUSH: begin
                // Tag and target are left in place; only valid/counter reset
                wr_en          = 1'b1;
                wr_idx         = flush_idx_q;
                wr_entry       = table_q[flush_idx_q];
                wr_entry.valid = 1'b0;
                wr_entry.ctr   = CTR_STRONG_NT;
                if (btb_ctrl_flush) begin
                    flush_idx_d = '0;
                end else if (flush_idx_q == LAST_IDX) begin
                    state_d     = IDLE;
                    flush_idx_d = '0;
                end else begin
                    flush_idx_d = flush_idx_q + 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                flush_idx_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM state and flush walk pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge btb_ctrl_clk or negedge btb_ctrl_rst_n) begin
        if (!btb_ctrl_rst_n) begin
            state_q     <= IDLE;
            flush_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
        end
    end

    // Capture the accepted update for the read-modify-write cycle
    always_ff @(posedge btb_ctrl_clk or negedge btb_ctrl_rst_n) begin
        if (!btb_ctrl_rst_n) begin
            upd_pc_q     <= '0;
            upd_taken_q  <= 1'b0;
            upd_target_q <= '0;
        end else if (latch_en) begin
            upd_pc_q     <= btb_ctrl_upd_pc[ADDR_W-1:2];
            upd_taken_q  <= btb_ctrl_upd_taken;
            upd_target_q <= btb_ctrl_upd_target;
        end
    end

    // Table storage: one entry written per cycle at most
    always_ff @(posedge btb_ctrl_clk or negedge btb_ctrl_rst_n) begin
        if (!btb_ctrl_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en) begin
            table_q[wr_idx] <= wr_entry;
        end
    end

endmodule : btb_update_controller
`default_nettype wire

// File: tb/tb_btb_update_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btb_update_controller
//  Description : Directed bench for btb_update_controller. Stimulus pushes
//                hand-computed expectations into a queue; a monitor drains
//                and compares them against the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_update_controller;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] lookup_pc;
    logic        hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        busy;

    btb_update_controller #(.ENTRIES(16), .ADDR_W(32)) dut (
        .btb_ctrl_clk         (clk),
        .btb_ctrl_rst_n       (rst_n),
        .btb_ctrl_flush       (flush),
        .btb_ctrl_lookup_pc   (lookup_pc),
        .btb_ctrl_hit         (hit),
        .btb_ctrl_pred_taken  (pred_taken),
        .btb_ctrl_pred_target (pred_target),
        .btb_ctrl_upd_valid   (upd_valid),
        .btb_ctrl_upd_ready   (upd_ready),
        .btb_ctrl_upd_pc      (upd_pc),
        .btb_ctrl_upd_taken   (upd_taken),
        .btb_ctrl_upd_target  (upd_target),
        .btb_ctrl_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk_lk;
        logic        hit;
        logic        pt;
        logic [31:0] tgt;
        logic        chk_ctl;
        logic        busy;
        logic        ready;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  samp  = 1'b0;

    // Monitor: compare every queued expectation at the falling edge, or
    // immediately when stimulus requests an off-clock sample
    always @(negedge clk or posedge samp) begin
        exp_t  e;
        string nm;
        bit    ok;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            ok = 1'b1;
            if (e.chk_lk && (hit !== e.hit || pred_taken !== e.pt || pred_target !== e.tgt))
                ok = 1'b0;
            if (e.chk_ctl && (busy !== e.busy || upd_ready !== e.ready))
                ok = 1'b0;
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s: hit/pt/tgt/busy/rdy got %b/%b/%h/%b/%b expected %b/%b/%h/%b/%b",
                         nm, hit, pred_taken, pred_target, busy, upd_ready,
                         e.hit, e.pt, e.tgt, e.busy, e.ready);
            end
        end
    end

    task automatic push(input string nm, input bit lk, input bit h, input bit p,
                        input logic [31:0] t, input bit ctl, input bit b, input bit r);
        exp_t e;
        e.chk_lk  = lk;
        e.hit     = h;
        e.pt      = p;
        e.tgt     = t;
        e.chk_ctl = ctl;
        e.busy    = b;
        e.ready   = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check_int(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Idle lookup check; takes one cycle
    task automatic chk_lookup(input string nm, input logic [31:0] pc,
                              input bit h, input bit p, input logic [31:0] t);
        lookup_pc = pc;
        push(nm, 1, h, p, t, 1, 0, 1);
        @(posedge clk); #1;
    endtask

    // Offer one update; checks acceptance cycle and the UPDATE cycle, where
    // the lookup of the same PC must still show the old entry (oh/op/ot)
    task automatic do_update(input string nm, input logic [31:0] pc, input bit tk,
                             input logic [31:0] tgt, input bit oh, input bit op,
                             input logic [31:0] ot);
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        upd_valid  = 1'b1;
        lookup_pc  = pc;
        push({nm, "_offer"}, 1, oh, op, ot, 1, 0, 1);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        push({nm, "_busy"}, 1, oh, op, ot, 1, 1, 0);
        @(posedge clk); #1;
    endtask

    // Count busy cycles, raising flush during cycle number reassert_at
    task automatic count_busy(input int reassert_at, output int n);
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            flush = (k == reassert_at);
            @(negedge clk);
            if (!busy) break;
            n++;
            @(posedge clk); #1;
        end
        flush = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        flush      = 1'b0;
        lookup_pc  = 32'h0;
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        chk_lookup("reset_lookup", 32'h100, 0, 0, 32'h0);

        // Allocation and counter walk at 0x100
        do_update("alloc", 32'h100, 1, 32'h200, 0, 0, 32'h0);
        chk_lookup("alloc_hit", 32'h100, 1, 1, 32'h200);
        do_update("nt1", 32'h100, 0, 32'h999, 1, 1, 32'h200);
        chk_lookup("nt1_ctr01", 32'h100, 1, 0, 32'h200);
        do_update("nt2", 32'h100, 0, 32'h999, 1, 0, 32'h200);
        chk_lookup("nt2_ctr00", 32'h100, 1, 0, 32'h200);
        do_update("t1", 32'h100, 1, 32'h204, 1, 0, 32'h200);
        chk_lookup("t1_ctr01", 32'h100, 1, 0, 32'h204);
        do_update("t2", 32'h100, 1, 32'h204, 1, 0, 32'h204);
        chk_lookup("t2_ctr10", 32'h100, 1, 1, 32'h204);
        do_update("t3", 32'h100, 1, 32'h204, 1, 1, 32'h204);
        do_update("t4", 32'h100, 1, 32'h204, 1, 1, 32'h204);
        chk_lookup("t4_ctr11", 32'h100, 1, 1, 32'h204);
        do_update("nt3", 32'h100, 0, 32'h0, 1, 1, 32'h204);
        chk_lookup("nt3_ctr10", 32'h100, 1, 1, 32'h204);
        do_update("nt4", 32'h100, 0, 32'h0, 1, 1, 32'h204);
        chk_lookup("nt4_ctr01", 32'h100, 1, 0, 32'h204);

        // Aliasing at index 0
        do_update("alias", 32'h140, 1, 32'h300, 0, 0, 32'h0);
        chk_lookup("alias_old", 32'h100, 0, 0, 32'h0);
        chk_lookup("alias_new", 32'h140, 1, 1, 32'h300);
        do_update("nt_miss", 32'h180, 0, 32'h400, 0, 0, 32'h0);
        chk_lookup("nt_miss_noalloc", 32'h180, 0, 0, 32'h0);
        chk_lookup("nt_miss_keep", 32'h140, 1, 1, 32'h300);
        do_update("idx1", 32'h104, 1, 32'h500, 0, 0, 32'h0);
        chk_lookup("pc_lsb_ignored", 32'h107, 1, 1, 32'h500);

        // Flush with a simultaneous update offer: exactly 16 busy cycles
        flush      = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h108;
        upd_taken  = 1'b1;
        upd_target = 32'h600;
        push("flush_refuse", 0, 0, 0, 32'h0, 1, 0, 0);
        @(posedge clk); #1;
        flush     = 1'b0;
        upd_valid = 1'b0;
        lookup_pc = 32'h140;
        for (int i = 1; i <= 16; i++) begin
            push($sformatf("flush_cyc%0d", i), 1, 0, 0, 32'h0, 1, 1, 0);
            @(posedge clk); #1;
        end
        push("flush_done", 1, 0, 0, 32'h0, 1, 0, 1);
        @(posedge clk); #1;
        chk_lookup("flush_clr_idx1", 32'h104, 0, 0, 32'h0);
        chk_lookup("flush_no_upd", 32'h108, 0, 0, 32'h0);

        // Flush re-asserted during the 5th walk cycle
        do_update("refill", 32'h140, 1, 32'h300, 0, 0, 32'h0);
        flush = 1'b1;
        @(posedge clk); #1;
        count_busy(5, n);
        check_int("flush_restart_cycles", n, 21);
        chk_lookup("restart_clr", 32'h140, 0, 0, 32'h0);

        // Flush during UPDATE: update dropped, 1 UPDATE + 16 FLUSH cycles
        upd_pc     = 32'h10C;
        upd_taken  = 1'b1;
        upd_target = 32'h700;
        upd_valid  = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        count_busy(1, n);
        check_int("flush_in_update_cycles", n, 17);
        chk_lookup("flush_in_update_drop", 32'h10C, 0, 0, 32'h0);

        // Asynchronous reset during a flush walk
        do_update("pre_rst", 32'h104, 1, 32'h500, 0, 0, 32'h0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        lookup_pc = 32'h104;
        push("mid_flush", 1, 0, 0, 32'h0, 1, 1, 0);
        @(negedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        push("async_reset", 1, 0, 0, 32'h0, 1, 0, 1);
        samp = 1'b1;
        #1;
        samp = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_lookup("after_reset", 32'h104, 0, 0, 32'h0);

        @(negedge clk); #1;
        check_int("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_btb_update_controller
`default_nettype wire
